// File: rtl/display_arbiter_pkg.sv
// Shared state encoding, default parameters and sizing helpers for the display arbiter.
package display_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2,
      ST_OVR   = 2'd3
   } state_t;

   localparam int DEF_N_SRC        = 8;
   localparam int DEF_SEL_W        = 3;
   localparam int DEF_SEG_W        = 8;
   localparam int DEF_TUBE_W       = 8;
   localparam int DEF_BLANK_CYCLES = 1000;
   localparam int DEF_OVR_CYCLES   = 100000000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Narrowest counter that can hold the longer of the two timed intervals.
   function automatic int timer_width(input int blank_cycles, input int ovr_cycles);
      return $clog2(max_int(blank_cycles, ovr_cycles) + 1);
   endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Bundle of source buses, control requests and display outputs between the mode logic and the arbiter.
interface display_arbiter_if import display_pkg::*; #(
   parameter int N_SRC  = DEF_N_SRC,
   parameter int SEL_W  = DEF_SEL_W,
   parameter int SEG_W  = DEF_SEG_W,
   parameter int TUBE_W = DEF_TUBE_W
);

   logic                      power_on;
   logic [SEL_W-1:0]          sel;
   logic [N_SRC*SEG_W-1:0]    src_digit1;
   logic [N_SRC*SEG_W-1:0]    src_digit2;
   logic [N_SRC*TUBE_W-1:0]   src_tube;
   logic                      ovr_req;
   logic [SEL_W-1:0]          ovr_sel;

   logic [SEG_W-1:0]          digit1;
   logic [SEG_W-1:0]          digit2;
   logic [TUBE_W-1:0]         tube_sel;
   logic [SEL_W-1:0]          active_sel;
   logic                      ovr_active;
   logic                      blanking;

   // The master side owns the sources and requests; the arbiter is the slave.
   modport master (
      output power_on, sel, src_digit1, src_digit2, src_tube, ovr_req, ovr_sel,
      input  digit1, digit2, tube_sel, active_sel, ovr_active, blanking
   );

   modport slave (
      input  power_on, sel, src_digit1, src_digit2, src_tube, ovr_req, ovr_sel,
      output digit1, digit2, tube_sel, active_sel, ovr_active, blanking
   );

endinterface

// File: rtl/display_arbiter_cycle_timer.sv
// Loadable down-counter that saturates at zero; shared by the blank gap and the override hold.
module cycle_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero,
   output logic         last
);

   logic [W-1:0] count;

   // A load always wins; otherwise count down and hold at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);
   assign last = (count <= W'(1));

endmodule

// File: rtl/display_arbiter.sv
// Chooses which display source drives the tubes, with a blank gap on switches and a timed override.
module display_arbiter import display_pkg::*; #(
   parameter int N_SRC        = DEF_N_SRC,
   parameter int SEL_W        = DEF_SEL_W,
   parameter int SEG_W        = DEF_SEG_W,
   parameter int TUBE_W       = DEF_TUBE_W,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
   parameter int OVR_CYCLES   = DEF_OVR_CYCLES
) (
   input logic              clk,
   input logic              rst,
   display_arbiter_if.slave bus
);

   localparam int TMR_W = timer_width(BLANK_CYCLES, OVR_CYCLES);
   localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'(BLANK_CYCLES);
   localparam logic [TMR_W-1:0] OVR_LOAD   = TMR_W'(OVR_CYCLES);

   state_t             state;
   state_t             state_nx;
   logic [SEL_W-1:0]   active_sel;
   logic [SEL_W-1:0]   active_nx;
   logic [SEL_W-1:0]   sel_c;
   logic [SEL_W-1:0]   ovr_c;
   logic               tmr_load;
   logic [TMR_W-1:0]   tmr_val;
   logic               tmr_zero;
   logic               tmr_last;
   logic               show_nx;
   logic [SEG_W-1:0]   digit1_q;
   logic [SEG_W-1:0]   digit2_q;
   logic [TUBE_W-1:0]  tube_q;

   // Indices that name no real source fall back to source 0.
   function automatic logic [SEL_W-1:0] clamp_idx(input logic [SEL_W-1:0] idx);
      return (32'(idx) < 32'(N_SRC)) ? idx : '0;
   endfunction

   assign sel_c = clamp_idx(bus.sel);
   assign ovr_c = clamp_idx(bus.ovr_sel);

   cycle_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero),
      .last     (tmr_last)
   );

   // Power-off beats override, override beats a sel change, and a sel change beats timer expiry.
   // BLANK ends when the timer has already reached zero, so it lasts BLANK_CYCLES+1 cycles,
   // while OVR ends on the cycle the timer would reach zero, so it lasts exactly OVR_CYCLES.
   always_comb begin
      state_nx  = state;
      active_nx = active_sel;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      if (!bus.power_on) begin
         state_nx  = ST_OFF;
         active_nx = '0;
         tmr_load  = 1'b1;
      end else if (state == ST_OFF) begin
         state_nx  = ST_BLANK;
         active_nx = sel_c;
         tmr_load  = 1'b1;
         tmr_val   = BLANK_LOAD;
      end else if (bus.ovr_req) begin
         state_nx  = ST_OVR;
         active_nx = ovr_c;
         tmr_load  = 1'b1;
         tmr_val   = OVR_LOAD;
      end else begin
         case (state)
            ST_BLANK: begin
               if (tmr_zero) begin
                  state_nx  = ST_SHOW;
                  active_nx = sel_c;
               end
            end
            ST_SHOW: begin
               if (sel_c != active_sel) begin
                  state_nx  = ST_BLANK;
                  active_nx = sel_c;
                  tmr_load  = 1'b1;
                  tmr_val   = BLANK_LOAD;
               end
            end
            ST_OVR: begin
               if (tmr_last) begin
                  state_nx = ST_BLANK;
                  tmr_load = 1'b1;
                  tmr_val  = BLANK_LOAD;
               end
            end
            default: begin
               state_nx = ST_OFF;
            end
         endcase
      end
   end

   assign show_nx = (state_nx == ST_SHOW) || (state_nx == ST_OVR);

   // Output registers follow the state being entered, so the tubes go dark on the same edge blanking rises.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_OFF;
         active_sel <= '0;
         digit1_q   <= '0;
         digit2_q   <= '0;
         tube_q     <= '0;
      end else begin
         state      <= state_nx;
         active_sel <= active_nx;
         if (show_nx) begin
            digit1_q <= bus.src_digit1[active_nx*SEG_W +: SEG_W];
            digit2_q <= bus.src_digit2[active_nx*SEG_W +: SEG_W];
            tube_q   <= bus.src_tube[active_nx*TUBE_W +: TUBE_W];
         end else begin
            digit1_q <= '0;
            digit2_q <= '0;
            tube_q   <= '0;
         end
      end
   end

   assign bus.digit1     = digit1_q;
   assign bus.digit2     = digit2_q;
   assign bus.tube_sel   = tube_q;
   assign bus.active_sel = active_sel;
   assign bus.ovr_active = (state == ST_OVR);
   assign bus.blanking   = (state == ST_OFF) || (state == ST_BLANK);

endmodule
